// File: rtl/button_conditioner.sv
// Debounces one raw active-low push button and turns it into a press strobe,
// optional auto-repeat strobes while held, and a clean held level.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 12_500_000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic butt_n,
    output logic pulse,
    output logic held,
    output logic repeat_active
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HOLD     = 3'd2,
        REPEAT   = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             sync1, sync2;
    logic             pulse_nx, held_nx, repeat_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            pulse         <= 1'b0;
            held          <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            sync1         <= butt_n;
            sync2         <= sync1;
            pulse         <= pulse_nx;
            held          <= held_nx;
            repeat_active <= repeat_nx;
        end
    end

    // The timer restarts from zero whenever the state changes.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!sync2) state_nx = PRESS_DB;
            end
            PRESS_DB: begin
                if (sync2) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end
            end
            HOLD: begin
                if (sync2) begin
                    state_nx = REL_DB;
                    cnt_nx   = '0;
                end else if (cnt == RD_LAST) begin
                    if (REPEAT_EN) begin
                        state_nx = REPEAT;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt;
                    end
                end
            end
            REPEAT: begin
                if (sync2) begin
                    state_nx = REL_DB;
                    cnt_nx   = '0;
                end else if (cnt == RP_LAST) begin
                    cnt_nx = '0;
                end
            end
            REL_DB: begin
                if (!sync2) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are registered copies of what the next state implies.
    always_comb begin
        held_nx   = (state_nx == HOLD) || (state_nx == REPEAT) || (state_nx == REL_DB);
        repeat_nx = (state_nx == REPEAT);
        pulse_nx  = ((state == PRESS_DB) && (state_nx == HOLD))
                 || ((state == HOLD) && (state_nx == REPEAT))
                 || ((state == REPEAT) && !sync2 && (cnt == RP_LAST));
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Random and directed stimulus for button_conditioner, checked each cycle
// against a run-length model of the debounce / repeat rules.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic butt_n = 1'b1;
    logic pulse_a, held_a, rep_a;
    logic pulse_b, held_b, rep_b;

    int total = 0;
    int bad = 0;
    int np_a = 0;
    int np_b = 0;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                         .REPEAT_EN(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .butt_n(butt_n),
        .pulse(pulse_a), .held(held_a), .repeat_active(rep_a));

    button_conditioner #(.DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                         .REPEAT_EN(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .butt_n(butt_n),
        .pulse(pulse_b), .held(held_b), .repeat_active(rep_b));

    // Model: the synchronised level is the raw input two edges late. A press
    // is accepted after DB+1 consecutive low samples, a release after DB+1
    // consecutive high samples; repeat pulses fall at hold_t = RD + n*RP,
    // where hold_t counts edges since the hold (re)started.
    bit s1m = 1'b1, s2m = 1'b1;
    bit hm[2], pm[2], rm[2];
    int lowrun[2], highrun[2], hold_t[2];

    always @(posedge clk) begin
        if (!rst_n) begin
            s1m = 1'b1;
            s2m = 1'b1;
            for (int i = 0; i < 2; i++) begin
                hm[i] = 0; pm[i] = 0; rm[i] = 0;
                lowrun[i] = 0; highrun[i] = 0; hold_t[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit en;
                en = (i == 0);
                pm[i] = 0;
                if (!hm[i]) begin
                    lowrun[i] = s2m ? 0 : lowrun[i] + 1;
                    if (lowrun[i] == DB + 1) begin
                        hm[i] = 1; pm[i] = 1; hold_t[i] = 0; highrun[i] = 0;
                    end
                end else if (s2m) begin
                    highrun[i]++;
                    if (highrun[i] == DB + 1) begin
                        hm[i] = 0; lowrun[i] = 0; highrun[i] = 0;
                    end
                end else if (highrun[i] > 0) begin
                    hold_t[i] = 0;
                    highrun[i] = 0;
                end else begin
                    hold_t[i]++;
                    if (en && hold_t[i] >= RD && (hold_t[i] - RD) % RP == 0) pm[i] = 1;
                end
                rm[i] = hm[i] && en && !s2m && highrun[i] == 0 && hold_t[i] >= RD;
            end
            s2m = s1m;
            s1m = butt_n;
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check the outputs left by the previous edge, then drive the next inputs.
    task automatic tick(input logic b, input logic r);
        @(negedge clk);
        chk("pulse_a", pulse_a, pm[0]);
        chk("held_a", held_a, hm[0]);
        chk("repeat_a", rep_a, rm[0]);
        chk("pulse_b", pulse_b, pm[1]);
        chk("held_b", held_b, hm[1]);
        chk("repeat_b", rep_b, rm[1]);
        if (pulse_a) np_a++;
        if (pulse_b) np_b++;
        butt_n = b;
        rst_n = r;
    endtask

    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) tick(b, 1'b1);
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        // reset with a toggling button
        for (int i = 0; i < 3; i++) tick(i[0], 1'b0);
        tick(1'b1, 1'b1);
        np_a = 0; np_b = 0;
        run(1'b1, 50);
        chk_int("idle_pulses", np_a + np_b, 0);

        // clean press
        np_a = 0; np_b = 0;
        run(1'b0, 12);
        run(1'b1, 15);
        chk_int("press_a", np_a, 1);
        chk_int("press_b", np_b, 1);

        // bounce rejection, then a stable press
        np_a = 0; np_b = 0;
        for (int i = 0; i < 5; i++) begin
            run(1'b0, 3);
            run(1'b1, 1);
        end
        run(1'b1, 4);
        chk_int("bounce_a", np_a, 0);
        chk_int("bounce_b", np_b, 0);
        run(1'b0, 12);
        run(1'b1, 15);
        chk_int("after_bounce_a", np_a, 1);

        // auto-repeat; release lands on a repeat terminal count
        np_a = 0; np_b = 0;
        run(1'b0, 39);
        run(1'b1, 15);
        chk_int("repeat_a", np_a, 6);
        chk_int("norepeat_b", np_b, 1);

        // reset in the middle of repeating, button kept down
        run(1'b0, 24);
        tick(1'b0, 1'b0);
        np_a = 0; np_b = 0;
        run(1'b0, 14);
        chk_int("rst_press_a", np_a, 1);
        chk_int("rst_press_b", np_b, 1);
        run(1'b1, 15);

        // random runs with occasional reset
        for (int k = 0; k < 1500; k++) begin
            logic lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 16);
            if ($urandom_range(0, 99) == 0) tick(lvl, 1'b0);
            run(lvl, len);
        end
        run(1'b1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
